// File: rtl/spi_master.sv
// Memory-mapped SPI master (mode 0, MSB first) with DATA/CTRL/DIV registers
// on the 8-bit IO bus and a sticky transfer-complete flag.
module spi_master #(
    parameter logic [7:0] SPI_ADDRESS = 8'h0D
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] din,
    input  logic [7:0] address,
    input  logic       w_en,
    input  logic       r_en,
    output logic [7:0] dout,
    output logic       sck,
    output logic       mosi,
    input  logic       miso,
    output logic       cs_n,
    output logic       done_flag,
    input  logic       done_flag_clr
);
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        LOW  = 2'b01,
        HIGH = 2'b10
    } state_t;

    localparam logic [7:0] ADDR_DATA = SPI_ADDRESS;
    localparam logic [7:0] ADDR_CTRL = SPI_ADDRESS + 8'd1;
    localparam logic [7:0] ADDR_DIV  = SPI_ADDRESS + 8'd2;

    state_t     state_q;
    logic       sck_q;
    logic       mosi_q;
    logic       cs_n_q;
    logic       done_flag_q;
    logic       done_flag_d;
    logic [7:0] tx_q;
    logic [7:0] rx_q;
    logic [7:0] rx_data_q;
    logic [7:0] div_q;
    logic [7:0] div_cnt_q;
    logic [7:0] dout_q;
    logic [7:0] dout_d;
    logic [2:0] bit_cnt_q;

    logic sel_data_s;
    logic sel_ctrl_s;
    logic sel_div_s;
    logic busy_s;
    logic half_done_s;
    logic xfer_start_s;
    logic xfer_done_s;
    logic clr_req_s;

    assign sel_data_s   = (address == ADDR_DATA);
    assign sel_ctrl_s   = (address == ADDR_CTRL);
    assign sel_div_s    = (address == ADDR_DIV);
    assign busy_s       = (state_q != IDLE);
    // Equality compare keeps DIV=255 safe with an 8-bit divider counter.
    assign half_done_s  = (div_cnt_q == div_q);
    assign xfer_start_s = w_en && sel_data_s && (state_q == IDLE);
    assign xfer_done_s  = (state_q == HIGH) && half_done_s && (bit_cnt_q == 3'd0);
    assign clr_req_s    = done_flag_clr || (w_en && sel_ctrl_s && din[1]) || (r_en && sel_data_s);

    // Read mux and sticky-flag next state; completion beats any clear.
    always_comb begin
        dout_d      = 8'h00;
        done_flag_d = done_flag_q;
        if (r_en && sel_data_s) begin
            dout_d = rx_data_q;
        end else if (r_en && sel_ctrl_s) begin
            dout_d = {5'b00000, cs_n_q, done_flag_q, busy_s};
        end else if (r_en && sel_div_s) begin
            dout_d = div_q;
        end else begin
            dout_d = 8'h00;
        end
        if (xfer_done_s) begin
            done_flag_d = 1'b1;
        end else if (clr_req_s) begin
            done_flag_d = 1'b0;
        end else begin
            done_flag_d = done_flag_q;
        end
    end

    // Software-visible registers and registered read data.
    always_ff @(posedge clk) begin
        if (rst) begin
            cs_n_q      <= 1'b1;
            div_q       <= 8'h00;
            done_flag_q <= 1'b0;
            dout_q      <= 8'h00;
        end else begin
            if (w_en && sel_ctrl_s) begin
                cs_n_q <= din[2];
            end
            if (w_en && sel_div_s) begin
                div_q <= din;
            end
            done_flag_q <= done_flag_d;
            dout_q      <= dout_d;
        end
    end

    // Transfer FSM: LOW/HIGH half-periods of DIV+1 clocks, sample on rising sck.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            sck_q     <= 1'b0;
            mosi_q    <= 1'b0;
            tx_q      <= 8'h00;
            rx_q      <= 8'h00;
            rx_data_q <= 8'h00;
            bit_cnt_q <= 3'd0;
            div_cnt_q <= 8'h00;
        end else begin
            case (state_q)
                IDLE: begin
                    if (xfer_start_s) begin
                        state_q   <= LOW;
                        tx_q      <= din;
                        mosi_q    <= din[7];
                        bit_cnt_q <= 3'd7;
                        div_cnt_q <= 8'h00;
                    end
                end
                LOW: begin
                    if (half_done_s) begin
                        state_q   <= HIGH;
                        sck_q     <= 1'b1;
                        rx_q      <= {rx_q[6:0], miso};
                        div_cnt_q <= 8'h00;
                    end else begin
                        div_cnt_q <= div_cnt_q + 8'd1;
                    end
                end
                HIGH: begin
                    if (half_done_s) begin
                        sck_q     <= 1'b0;
                        div_cnt_q <= 8'h00;
                        if (bit_cnt_q == 3'd0) begin
                            state_q   <= IDLE;
                            rx_data_q <= rx_q;
                        end else begin
                            state_q   <= LOW;
                            tx_q      <= {tx_q[6:0], 1'b0};
                            mosi_q    <= tx_q[6];
                            bit_cnt_q <= bit_cnt_q - 3'd1;
                        end
                    end else begin
                        div_cnt_q <= div_cnt_q + 8'd1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    sck_q   <= 1'b0;
                end
            endcase
        end
    end

    assign dout      = dout_q;
    assign sck       = sck_q;
    assign mosi      = mosi_q;
    assign cs_n      = cs_n_q;
    assign done_flag = done_flag_q;

endmodule
